// File: rtl/rst_seq_ctrl_if.sv
// Handshake bundle between the reset sequencer and its downstream blocks.
// master = sequencer side, slave = block/stimulus side.
interface rst_seq_ctrl_if #(
  parameter int NUM_OUT = 4
);
  logic               soft_req;
  logic [NUM_OUT-1:0] ready;
  logic [NUM_OUT-1:0] rst_out;
  logic               busy;
  logic               seq_done;
  logic [NUM_OUT-1:0] err;

  modport master (
    input  soft_req,
    input  ready,
    output rst_out,
    output busy,
    output seq_done,
    output err
  );

  modport slave (
    output soft_req,
    output ready,
    input  rst_out,
    input  busy,
    input  seq_done,
    input  err
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Ordered reset release for the UART system blocks, with soft restart.
// Define RST_SEQ_TIMEOUT_EN to bound the READY wait and flag timeouts in err.
module rst_seq_ctrl #(
  parameter int NUM_OUT    = 4,
  parameter int MIN_ASSERT = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 8
) (
  input  logic           clk,
  input  logic           rst,
  rst_seq_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_ASSERT,
    S_WAIT_RDY,
    S_GAP,
    S_DONE
  } state_t;

  localparam int IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CNT_W-1:0] MIN_LAST =
    CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_OUT - 1);

  if (NUM_OUT < 1 || MIN_ASSERT < 1 || TIMEOUT < 1
      || GAP_CYCLES < 0
      || MIN_ASSERT >= (1 << CNT_W)
      || GAP_CYCLES >= (1 << CNT_W)
      || TIMEOUT >= (1 << CNT_W)) begin : g_bad_cfg
    $error("rst_seq_ctrl: illegal parameter set");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
  logic [IW-1:0]      idx_inc;
  logic               rdy;
  logic               adv;

`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT - 1);
  logic [NUM_OUT-1:0] err_q, err_d;
`endif

  assign idx_inc = idx_q + IW'(1);
  assign rdy     = bus.ready[idx_q];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    adv       = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
    err_d     = err_q;
`endif

    unique case (state_q)
      S_ASSERT: begin
        if (cnt_q == MIN_LAST) begin
          rst_out_d[0] = 1'b1;
          cnt_d        = '0;
          state_d      = S_WAIT_RDY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_RDY: begin
`ifdef RST_SEQ_TIMEOUT_EN
        // a READY on the terminal edge beats the timeout
        if (rdy) begin
          adv = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          adv          = 1'b1;
          err_d[idx_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        adv = rdy;
`endif
        if (adv) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else if (GAP_CYCLES == 0) begin
            rst_out_d[idx_inc] = 1'b1;
            idx_d              = idx_inc;
          end else begin
            state_d = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          rst_out_d[idx_inc] = 1'b1;
          idx_d              = idx_inc;
          cnt_d              = '0;
          state_d            = S_WAIT_RDY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_ASSERT;
      end
    endcase

    // soft restart overrides the sequence but not the system reset
    if (bus.soft_req) begin
      state_d   = S_ASSERT;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '0;
`ifdef RST_SEQ_TIMEOUT_EN
      err_d     = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_ASSERT;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '0;
`ifdef RST_SEQ_TIMEOUT_EN
      err_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
`ifdef RST_SEQ_TIMEOUT_EN
      err_q     <= err_d;
`endif
    end
  end

  assign bus.rst_out  = rst_out_q;
  assign bus.busy     = (state_q != S_DONE);
  assign bus.seq_done = (state_q == S_DONE);
`ifdef RST_SEQ_TIMEOUT_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = '0;
`endif

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset sequencer for the UART system's downstream blocks. It takes the already-synchronized system reset, holds all block resets asserted for a minimum time, then releases them one at a time in index order. Each release waits for that block's READY before a programmable gap and the next release. A soft-reset request restarts the whole sequence without touching the system reset.

## Interface
Parameters:
- NUM_OUT, 4 — number of sequenced reset outputs (≥1)
- MIN_ASSERT, 4 — cycles all outputs are held asserted before the first release (≥1)
- GAP_CYCLES, 2 — cycles between a READY and the next release (0 allowed)
- TIMEOUT, 16 — READY wait limit in cycles (≥1); used only with RST_SEQ_TIMEOUT_EN
- CNT_W, 8 — counter width; MIN_ASSERT, GAP_CYCLES and TIMEOUT must all be < 2^CNT_W

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-low
- SOFT_REQ  in  1  level-sampled soft-reset request, active-high
- READY  in  NUM_OUT  per-block "out of reset" acknowledge
- RST_OUT  out  NUM_OUT  sequenced block resets, active-low, registered
- BUSY  out  1  high while the sequence is not complete
- SEQ_DONE  out  1  high once all outputs are released
- ERR  out  NUM_OUT  sticky per-block timeout flags

## Operation
- State machine: ASSERT, WAIT_RDY, GAP, DONE. Internal registers: idx (index of the block being sequenced) and cnt (CNT_W-bit counter).
- Reset (RST low at an edge):
  - state=ASSERT, cnt=0, idx=0.
  - RST_OUT=all 0, BUSY=1, SEQ_DONE=0, ERR=0.
- ASSERT:
  - If cnt==MIN_ASSERT-1: set RST_OUT[0]=1, cnt=0, go to WAIT_RDY.
  - Otherwise cnt increments.
- WAIT_RDY: only READY[idx] is examined.
  - READY[idx]=1 and idx==NUM_OUT-1: go to DONE.
  - READY[idx]=1 otherwise: if GAP_CYCLES==0, set RST_OUT[idx+1]=1, idx++, cnt=0 and stay in WAIT_RDY; else go to GAP with cnt=0.
- GAP:
  - If cnt==GAP_CYCLES-1: set RST_OUT[idx+1]=1, idx++, cnt=0, go to WAIT_RDY.
  - Otherwise cnt increments.
- DONE: hold. SEQ_DONE=1, BUSY=0.
- SOFT_REQ=1 at any edge (RST high):
  - Go to ASSERT with cnt=0, idx=0.
  - RST_OUT=0, SEQ_DONE=0, BUSY=1, ERR=0.
  - Holding SOFT_REQ high keeps cnt at 0; counting starts on the first edge with SOFT_REQ low.
- Priority: RST > SOFT_REQ > state logic.
- Released outputs stay 1 until RST or SOFT_REQ. Outputs never deassert out of index order.

## Timing
- All outputs are registered. BUSY and SEQ_DONE are decoded from registered state and change on the same edge as the state.
- Edge numbering: edge 1 is the first edge with RST high and SOFT_REQ low.
- RST_OUT[0] rises at edge MIN_ASSERT.
- READY[idx] is first sampled on the edge after RST_OUT[idx] rises. Minimum READY latency is therefore 1 cycle.
- READY[idx] sampled high at edge e:
  - RST_OUT[idx+1] rises at edge e+GAP_CYCLES, or at edge e itself when GAP_CYCLES=0.
  - For the last block, SEQ_DONE rises at edge e.
- Minimum total sequence time (READY tied high, GAP_CYCLES≥1): MIN_ASSERT + (NUM_OUT-1)·(1+GAP_CYCLES) + 1 cycles.

## Configuration
- RST_SEQ_TIMEOUT_EN defined:
  - In WAIT_RDY, cnt increments each edge while READY[idx]=0.
  - At cnt==TIMEOUT-1 with READY[idx] still 0: set ERR[idx]=1 and proceed exactly as if READY[idx] had been sampled high.
  - READY[idx]=1 on the terminal edge wins; ERR[idx] is not set.
- RST_SEQ_TIMEOUT_EN undefined:
  - WAIT_RDY waits indefinitely.
  - ERR is constant 0; TIMEOUT is unused.

## Test plan
- Basic sequence: NUM_OUT=4, MIN_ASSERT=4, GAP_CYCLES=2, READY tied high, RST released before edge 1 → RST_OUT[0] at edge 4, [1] at edge 7, [2] at edge 10, [3] at edge 13, SEQ_DONE/BUSY toggle at edge 14.
- Slow READY: READY[1] asserted 5 cycles after RST_OUT[1] rises → RST_OUT[2] rises exactly 2 edges after READY[1] is sampled; RST_OUT[2] stays 0 before then.
- Zero gap: GAP_CYCLES=0, READY tied high → consecutive RST_OUT bits rise one cycle apart.
- Soft reset mid-sequence: SOFT_REQ pulsed while idx=2 → RST_OUT=0 on the next edge; SOFT_REQ held 3 cycles then restart timing matches the basic case, counted from the first edge with SOFT_REQ low. Repeat the pulse in DONE → same restart.
- Sync reset: RST low for 1 cycle during GAP → all outputs at reset values on that edge. RST changing between edges has no effect until the next edge.
- Timeout (RST_SEQ_TIMEOUT_EN, TIMEOUT=16): READY[2] never asserted → ERR[2]=1 at the 16th edge in WAIT_RDY and the sequence completes. READY[2] asserted on exactly that edge → ERR[2] stays 0. Without the macro the same stimulus leaves BUSY=1 indefinitely.
